button_event_decoder: RTL

Consumes the clean, debounced button level and classifies it into discrete user events: PRESS, RELEASE, LONG, DOUBLE. Events are queued in a small FIFO and handed to downstream control logic over a valid/ready interface. It sits directly downstream of the switch debouncer and is the consumer end of the debounced-level interface. Timing uses an internal tick prescaler, so thresholds are expressed in ticks.

---
 rtl/button_pkg.sv | 20 ++
 rtl/evt_fifo.sv | 52 +++++
 rtl/button_event_decoder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/button_pkg.sv
// Shared definitions for the button event decoder: event codes and FSM encoding.
package button_pkg;

  localparam int EVT_W = 3;

  localparam logic [EVT_W-1:0] EVT_NONE    = 3'd0;
  localparam logic [EVT_W-1:0] EVT_PRESS   = 3'd1;
  localparam logic [EVT_W-1:0] EVT_RELEASE = 3'd2;
  localparam logic [EVT_W-1:0] EVT_LONG    = 3'd3;
  localparam logic [EVT_W-1:0] EVT_DOUBLE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HELD     = 3'd1,
    LONGHELD = 3'd2,
    GAP      = 3'd3,
    HELD2    = 3'd4
  } state_t;

endpackage

// File: rtl/evt_fifo.sv
// Small event queue; head entry is visible combinationally, and a pop frees room for a same-cycle push.
module evt_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers are log2(DEPTH) wide so they wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into PRESS/RELEASE/LONG/DOUBLE events and queues them
// for a valid/ready consumer. Hold and gap times are measured in prescaler ticks.
module button_event_decoder
  import button_pkg::*;
#(
  parameter int TICK_BITS  = 5,
  parameter int CNT_W      = 4,
  parameter int LONG_TICKS = 8,
  parameter int DBL_TICKS  = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       level_in,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [2:0] evt_code,
  output logic       ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W:0]   LONG_LIM = (CNT_W+1)'(LONG_TICKS);
  localparam logic [CNT_W:0]   DBL_LIM  = (CNT_W+1)'(DBL_TICKS);

  logic [TICK_BITS-1:0] presc;
  logic                 tick;
  logic                 prev_level;
  logic                 rise;
  logic                 fall;
  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_next;
  logic [CNT_W:0]       cnt_inc;
  logic [CNT_W-1:0]     cnt_sat;
  logic                 push;
  logic [2:0]           push_code;
  logic                 pop;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [2:0]           head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc      <= '0;
      prev_level <= 1'b0;
    end else begin
      presc      <= presc + TICK_BITS'(1);
      prev_level <= level_in;
    end
  end

  assign tick    = (presc == '0);
  assign rise    = level_in & ~prev_level;
  assign fall    = ~level_in & prev_level;
  assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
  assign cnt_sat = cnt_inc[CNT_W] ? CNT_MAX : cnt_inc[CNT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Edges take priority over tick thresholds; the counter is cleared on every state entry.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (rise) begin
          state_next = HELD;
          cnt_next   = '0;
        end
      end
      HELD, HELD2: begin
        if (fall) begin
          state_next = (state == HELD) ? GAP : IDLE;
          cnt_next   = '0;
        end else if (tick) begin
          if (cnt_inc == LONG_LIM) begin
            state_next = LONGHELD;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_sat;
          end
        end
      end
      LONGHELD: begin
        if (fall) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      GAP: begin
        if (rise) begin
          state_next = HELD2;
          cnt_next   = '0;
        end else if (tick) begin
          if (cnt_inc == DBL_LIM) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_sat;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    push      = 1'b0;
    push_code = EVT_NONE;
    case (state)
      IDLE: begin
        if (rise) begin
          push      = 1'b1;
          push_code = EVT_PRESS;
        end
      end
      HELD, HELD2: begin
        if (fall) begin
          push      = 1'b1;
          push_code = EVT_RELEASE;
        end else if (tick && cnt_inc == LONG_LIM) begin
          push      = 1'b1;
          push_code = EVT_LONG;
        end
      end
      LONGHELD: begin
        if (fall) begin
          push      = 1'b1;
          push_code = EVT_RELEASE;
        end
      end
      GAP: begin
        if (rise) begin
          push      = 1'b1;
          push_code = EVT_DOUBLE;
        end
      end
      default: begin
        push      = 1'b0;
        push_code = EVT_NONE;
      end
    endcase
  end

  evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_code),
    .pop   (pop),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign evt_valid = ~fifo_empty;
  assign evt_code  = fifo_empty ? EVT_NONE : head;
  assign pop       = evt_valid & evt_ready;

  // A push into a full queue with no simultaneous pop is lost; remember that it happened.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      ovf <= 1'b1;
    end
  end

endmodule
